// File: rtl/fft_frame_sched_if.sv
// fft_frame_sched_if
// Bundles the sample-capture, FFT-core and bin-output signals of the frame
// scheduler into one interface.
//   master : the environment side (I2S receiver + FFT core + bin consumer);
//            drives sample_valid/sample_in/fft_done/fft_wd.
//   slave  : the scheduler side; drives fft_load/fft_rd/fft_start,
//            out_valid/out_idx/out_data and the busy/overrun/drop_cnt status.
interface fft_frame_sched_if #(
    parameter int width = 16,
    parameter int N_2   = 5
);
    logic                      sample_valid;
    logic signed [width-1:0]   sample_in;
    logic                      fft_done;
    logic [2*width-1:0]        fft_wd;
    logic                      fft_load;
    logic [width-1:0]          fft_rd;
    logic                      fft_start;
    logic                      out_valid;
    logic [N_2-1:0]            out_idx;
    logic [2*width-1:0]        out_data;
    logic                      busy;
    logic                      overrun;
    logic [7:0]                drop_cnt;

    modport master (
        output sample_valid, sample_in, fft_done, fft_wd,
        input  fft_load, fft_rd, fft_start, out_valid, out_idx, out_data,
               busy, overrun, drop_cnt
    );

    modport slave (
        input  sample_valid, sample_in, fft_done, fft_wd,
        output fft_load, fft_rd, fft_start, out_valid, out_idx, out_data,
               busy, overrun, drop_cnt
    );
endinterface

// File: rtl/fft_frame_sched.sv
// fft_frame_sched
// Frame scheduler between an I2S receiver and a streaming FFT core.
// Samples are captured into a ping-pong pair of N-sample banks. When a bank
// fills and the scheduler is idle, the bank is streamed into the FFT (N load
// cycles), the FFT is started, and the N output bins are captured and
// re-presented with one cycle of latency. Frames completing while the FFT
// path is busy are dropped and flagged.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   bus   : fft_frame_sched_if.slave (capture input, FFT load/start,
//           FFT output bins, busy/overrun/drop_cnt status)
// Optional feature: define FRAME_SCHED_DROPCNT_EN to build the saturating
// 8-bit dropped-frame counter; otherwise drop_cnt reads as zero.
module fft_frame_sched #(
    parameter int width = 16,
    parameter int N_2   = 5
) (
    input  logic             clk,
    input  logic             reset,
    fft_frame_sched_if.slave bus
);
    localparam int N = 2 ** N_2;
    localparam logic [N_2-1:0] LAST_IDX = N_2'(N - 1);

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, UNLOAD} state_t;

    state_t             state_q, state_d;
    logic [N_2-1:0]     wr_idx_q, wr_idx_d;
    logic [N_2-1:0]     ld_idx_q, ld_idx_d;
    logic [N_2-1:0]     un_idx_q, un_idx_d;
    logic [N_2-1:0]     out_idx_q, out_idx_d;
    logic               cap_bank_q, cap_bank_d;
    logic               proc_bank_q, proc_bank_d;
    logic               out_valid_q, out_valid_d;
    logic               overrun_q, overrun_d;
    logic [2*width-1:0] out_data_q, out_data_d;
    logic               frame_done;
    logic               drop;

    // Both banks live in one array; the bank select is the address MSB.
    logic [width-1:0]   bank_mem [2*N];
    logic [N_2:0]       wr_addr;
    logic [N_2:0]       rd_addr;
    logic [N_2-1:0]     ld_next;
    logic [width-1:0]   rd_data_q;

    assign ld_next = ld_idx_q + N_2'(1);
    assign wr_addr = {cap_bank_q, wr_idx_q};
    // The read is registered, so address one sample ahead: while idle, the
    // completing bank's index 0 (cap_bank_q becomes proc_bank on that edge),
    // and during LOAD the sample after the one currently presented.
    assign rd_addr = (state_q == LOAD) ? {proc_bank_q, ld_next}
                                       : {cap_bank_q, {N_2{1'b0}}};

    always_ff @(posedge clk) begin
        if (bus.sample_valid && !reset) begin
            bank_mem[wr_addr] <= bus.sample_in;
        end
        rd_data_q <= bank_mem[rd_addr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_idx_q    <= '0;
            ld_idx_q    <= '0;
            un_idx_q    <= '0;
            out_idx_q   <= '0;
            cap_bank_q  <= 1'b0;
            proc_bank_q <= 1'b0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_idx_q    <= wr_idx_d;
            ld_idx_q    <= ld_idx_d;
            un_idx_q    <= un_idx_d;
            out_idx_q   <= out_idx_d;
            cap_bank_q  <= cap_bank_d;
            proc_bank_q <= proc_bank_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            out_data_q  <= out_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_idx_d    = wr_idx_q;
        ld_idx_d    = ld_idx_q;
        un_idx_d    = un_idx_q;
        out_idx_d   = out_idx_q;
        cap_bank_d  = cap_bank_q;
        proc_bank_d = proc_bank_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        overrun_d   = overrun_q;

        frame_done = bus.sample_valid && (wr_idx_q == LAST_IDX);
        drop       = frame_done && (state_q != IDLE);

        // Capture never stalls; the index wraps naturally at N-1.
        if (bus.sample_valid) begin
            wr_idx_d = wr_idx_q + N_2'(1);
        end
        // During LOAD the capture bank keeps its side so the bank being
        // streamed into the FFT is never overwritten.
        if (frame_done && (state_q != LOAD)) begin
            cap_bank_d = ~cap_bank_q;
        end
        if (drop) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (frame_done) begin
                    proc_bank_d = cap_bank_q;
                    ld_idx_d    = '0;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                ld_idx_d = ld_next;
                if (ld_idx_q == LAST_IDX) begin
                    state_d = START;
                end
            end
            START: begin
                un_idx_d = '0;
                state_d  = WAIT;
            end
            WAIT, UNLOAD: begin
                // The first bin is taken in the same cycle done is seen.
                if (bus.fft_done) begin
                    out_valid_d = 1'b1;
                    out_idx_d   = un_idx_q;
                    out_data_d  = bus.fft_wd;
                    un_idx_d    = un_idx_q + N_2'(1);
                    state_d     = (un_idx_q == LAST_IDX) ? IDLE : UNLOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.fft_load  = (state_q == LOAD);
    assign bus.fft_rd    = (state_q == LOAD) ? rd_data_q : '0;
    assign bus.fft_start = (state_q == START);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_data  = out_data_q;
    assign bus.overrun   = overrun_q;

`ifdef FRAME_SCHED_DROPCNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= 8'h00;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.drop_cnt = drop_cnt_q;
`else
    assign bus.drop_cnt = 8'h00;
`endif
endmodule

// File: doc/fft_frame_sched.md
Name: fft_frame_sched

Overview:
- Frame scheduler between the I2S receiver and the streaming FFT core.
- Collects audio samples into a ping-pong pair of N-sample banks.
- When a bank fills, sequences the FFT: N-cycle load, one-cycle start, wait for done, then captures N complex output bins.
- Flags and counts frames dropped because the FFT was still busy.

Parameters:
- width, 16, sample and FFT real/imag component width in bits.
- N_2, 5, log2 of frame length; N = 2**N_2 = 32.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- sample_valid  input  1  one-cycle pulse: new sample on sample_in.
- sample_in  input  width  signed sample from the I2S receiver.
- fft_done  input  1  FFT core output-valid; stays high while bins stream out.
- fft_wd  input  2*width  FFT output bin {re[2w-1:w], im[w-1:0]}.
- fft_load  output  1  high during load; one sample per cycle into the FFT.
- fft_rd  output  width  sample presented to the FFT during load.
- fft_start  output  1  one-cycle start pulse.
- out_valid  output  1  bin valid this cycle.
- out_idx  output  N_2  bin index, 0..N-1.
- out_data  output  2*width  bin value, registered copy of fft_wd.
- busy  output  1  high in any state other than IDLE.
- overrun  output  1  sticky: a completed frame was dropped.
- drop_cnt  output  8  dropped-frame counter (see Optional Feature).

Behaviour:
- Reset (async, active-high) clears:
  - all outputs to 0;
  - wr_idx = 0, cap_bank = 0, state = IDLE.
  - Bank contents are not cleared.
- Reset mid-operation aborts any in-flight load or unload; the FFT is not re-started.
- Capture:
  - On sample_valid, write sample_in to bank[cap_bank][wr_idx]; wr_idx increments and wraps N-1 -> 0.
  - A write at wr_idx == N-1 is a frame-complete event, handled the same cycle:
    - state == IDLE: proc_bank <= cap_bank, cap_bank toggles, next state LOAD.
    - state == LOAD: frame dropped. No toggle, so the bank being loaded is never overwritten. Capture restarts at index 0 of the same bank; overrun set; drop_cnt increments.
    - START, WAIT or UNLOAD: cap_bank toggles, frame dropped, overrun set, drop_cnt increments.
- FSM:
  - IDLE: outputs low. Leaves only on frame-complete. fft_done is ignored.
  - LOAD (N cycles):
    - fft_load = 1 and fft_rd = bank[proc_bank][ld_idx], ld_idx = 0..N-1.
    - The first LOAD cycle is the cycle after frame-complete.
    - fft_rd is driven from registers (no combinational path from sample_in).
    - After ld_idx == N-1 -> START.
  - START (1 cycle): fft_start = 1, fft_load = 0, fft_rd = 0 -> WAIT.
  - WAIT: hold until fft_done == 1, then go to UNLOAD. The first bin is captured in the same cycle done is first seen.
  - UNLOAD:
    - Each cycle with fft_done high, register out_data <= fft_wd and out_idx <= un_idx; out_valid pulses 1 cycle later (1-cycle latency).
    - un_idx increments 0..N-1. If fft_done drops mid-unload, un_idx holds and out_valid is 0 that cycle.
    - After bin N-1 is captured -> IDLE. Further fft_done cycles are ignored.
- busy = (state != IDLE).
- overrun clears only on reset.
- Simultaneous sample_valid and FSM transitions are independent; capture never stalls.
- Minimum accepted frame period: N + 2 + FFT latency + N cycles.

Optional Feature:
- Macro FRAME_SCHED_DROPCNT_EN.
- Defined: drop_cnt is an 8-bit counter of dropped frames, saturating at 255 (no wrap), cleared by reset.
- Undefined: drop_cnt tied to 8'h00 and its counter logic omitted. overrun is still implemented.

Test Plan:
- Reset check: hold reset 4 cycles with sample_valid toggling -> all outputs 0, busy 0, no write; after release, first sample lands at index 0.
- Load sequence: feed 32 samples 16'h0000..16'h001F, one every 8 cycles -> one cycle after the 32nd, fft_load high for exactly 32 cycles with fft_rd 0x0000..0x001F in order; then fft_start high for 1 cycle.
- Unload: FFT model asserts fft_done 50 cycles after start and streams fft_wd = {16'h1000+k, 16'h2000+k} -> out_valid 32 pulses; out_idx 0..31; out_data matching, 1 cycle later; busy falls after bin 31; fft_done held 10 more cycles produces no out_valid.
- Overrun in WAIT: hold fft_done low, complete a 2nd frame -> overrun = 1, drop_cnt = 1 (macro on) or 0 (macro off), no second fft_start; a 3rd frame after returning to IDLE loads the 3rd-frame data.
- Overrun in LOAD: sample_valid every cycle so a 2nd frame completes during LOAD -> loaded data unchanged (original values); capture restarts at index 0 of the same bank.
- Mid-operation reset: assert reset during UNLOAD at bin 10 -> outputs 0 immediately; after release, FSM in IDLE and the next full frame processes normally; drop_cnt saturates at 255 after 300 forced drops.
